// File: rtl/dm_jtag_pkg.sv
// dm_jtag_pkg: shared DMI op/error/state types for the JTAG DTM access register
package dm_jtag_pkg;
  localparam int unsigned AbitsWDef = 7;
  localparam int unsigned DataWDef = 32;
  typedef enum logic [1:0] {Nop = 2'd0, Read = 2'd1, Write = 2'd2} dmi_op_e;
  typedef enum logic [1:0] {DmiNoError = 2'd0, DmiOpFailed = 2'd2, DmiBusy = 2'd3} dmi_error_e;
  typedef enum logic [2:0] {StIdle, StRead, StWaitRead, StWrite, StWaitWrite} dmi_dr_state_e;
  typedef struct packed {
    logic [AbitsWDef-1:0] addr;
    dmi_op_e op;
    logic [DataWDef-1:0] data;
  } dmi_req_t;
  typedef struct packed {
    logic [DataWDef-1:0] data;
    logic [1:0] resp;
  } dmi_resp_t;
endpackage

// File: rtl/dmi_jtag_dr_if.sv
// dmi_jtag_dr_if: DMI request/response channel between the DTM and the debug module CDC FIFO
interface dmi_jtag_dr_if #(
  parameter int unsigned AbitsW = 7,
  parameter int unsigned DataW = 32
);
  logic req_valid;
  logic req_ready;
  logic [AbitsW-1:0] req_addr;
  logic [1:0] req_op;
  logic [DataW-1:0] req_data;
  logic resp_valid;
  logic resp_ready;
  logic [DataW-1:0] resp_data;
  logic [1:0] resp_resp;
  modport master (
    output req_valid, req_addr, req_op, req_data, resp_ready,
    input req_ready, resp_valid, resp_data, resp_resp
  );
  modport slave (
    input req_valid, req_addr, req_op, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_resp
  );
endinterface

// File: rtl/dmi_jtag_dr.sv
// dmi_jtag_dr: DMIACCESS data register turning each Update-DR into one DMI handshake.
// Define DMI_JTAG_DR_TIMEOUT_EN to abort unanswered requests after TimeoutCycles.
module dmi_jtag_dr
  import dm_jtag_pkg::*;
#(
  parameter int unsigned AbitsW = 7,
  parameter int unsigned DataW = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic tck_i,
  input  logic rst_i,
  input  logic test_logic_reset_i,
  input  logic dmi_access_i,
  input  logic capture_dr_i,
  input  logic shift_dr_i,
  input  logic update_dr_i,
  input  logic dmi_reset_i,
  input  logic dmi_tdi_i,
  output logic dmi_tdo_o,
  output logic [1:0] dmi_error_o,
  dmi_jtag_dr_if.master dmi
);
  localparam int unsigned W = AbitsW + DataW + 2;
  logic [W-1:0] dr_q;
  logic [AbitsW-1:0] addr_q;
  logic [DataW-1:0] data_q;
  logic [1:0] error_q;
  dmi_dr_state_e state_q;
  logic rst, capture, shift, update, busy, resp_hs, fail, timeout;
  assign rst = rst_i | test_logic_reset_i;
  assign capture = dmi_access_i & capture_dr_i;
  assign shift = dmi_access_i & shift_dr_i;
  assign update = dmi_access_i & update_dr_i;
  assign busy = (state_q != StIdle) & (capture | update);
  assign resp_hs = dmi.resp_ready & dmi.resp_valid;
  assign fail = (resp_hs & (dmi.resp_resp != 2'd0)) | timeout;
  assign dmi_tdo_o = dr_q[0];
  assign dmi_error_o = error_q;
  assign dmi.req_valid = (state_q == StRead) | (state_q == StWrite);
  assign dmi.resp_ready = (state_q == StWaitRead) | (state_q == StWaitWrite);
  assign dmi.req_addr = addr_q;
  assign dmi.req_data = data_q;
  assign dmi.req_op = state_q == StRead ? Read : state_q == StWrite ? Write : Nop;
`ifdef DMI_JTAG_DR_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1) > 8 ? $clog2(TimeoutCycles + 1) : 8;
  logic [CntW-1:0] cnt_q;
  assign timeout = dmi.resp_ready & ~dmi.resp_valid & (cnt_q == CntW'(TimeoutCycles - 1));
  // Held at zero outside the wait states, so it starts fresh on every entry.
  always_ff @(posedge tck_i) begin
    if (rst || !dmi.resp_ready) cnt_q <= '0;
    else cnt_q <= cnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge tck_i) begin
    if (rst) begin
      dr_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      error_q <= DmiNoError;
      state_q <= StIdle;
    end else begin
      if (capture) dr_q <= {addr_q, data_q, busy ? 2'(DmiBusy) : error_q};
      else if (shift) dr_q <= {dmi_tdi_i, dr_q[W-1:1]};
      // First error sticks until dmireset, which also beats a same-cycle error.
      if (dmi_reset_i) error_q <= DmiNoError;
      else if (error_q == DmiNoError && (busy || fail)) error_q <= busy ? DmiBusy : DmiOpFailed;
      case (state_q)
        StIdle: if (update && error_q == DmiNoError) begin
          if (dr_q[1:0] == Read) begin
            addr_q <= dr_q[W-1:DataW+2];
            state_q <= StRead;
          end else if (dr_q[1:0] == Write) begin
            addr_q <= dr_q[W-1:DataW+2];
            data_q <= dr_q[DataW+1:2];
            state_q <= StWrite;
          end
        end
        StRead: if (dmi.req_ready) state_q <= StWaitRead;
        StWrite: if (dmi.req_ready) state_q <= StWaitWrite;
        StWaitRead, StWaitWrite: if (dmi.resp_valid || timeout) begin
          if (state_q == StWaitRead && dmi.resp_valid) data_q <= dmi.resp_data;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_dmi_jtag_dr.sv
// tb_dmi_jtag_dr: table-driven DMI transactions plus busy, failure, reset and timeout sequences
module tb_dmi_jtag_dr;
  import dm_jtag_pkg::*;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int W = AW + DW + 2;
  typedef struct {
    logic [6:0] addr;
    logic [31:0] data;
    logic [1:0] op;
    logic [31:0] rdata;
    logic [1:0] resp;
    logic [6:0] e_addr;
    logic [31:0] e_data;
    logic [1:0] e_op;
  } vec_t;
  logic tck_i = 1'b0;
  logic rst_i = 1'b0, tlr = 1'b0, acc = 1'b1, cap = 1'b0, sh = 1'b0, upd = 1'b0, drst = 1'b0, tdi = 1'b0;
  logic tdo;
  logic [1:0] err;
  logic [W-1:0] d;
  vec_t vecs[8];
  int errs = 0, checks = 0;
  dmi_jtag_dr_if #(.AbitsW(AW), .DataW(DW)) dmi ();
  dmi_jtag_dr #(.AbitsW(AW), .DataW(DW), .TimeoutCycles(4)) dut (
    .tck_i(tck_i), .rst_i(rst_i), .test_logic_reset_i(tlr), .dmi_access_i(acc),
    .capture_dr_i(cap), .shift_dr_i(sh), .update_dr_i(upd), .dmi_reset_i(drst),
    .dmi_tdi_i(tdi), .dmi_tdo_o(tdo), .dmi_error_o(err), .dmi(dmi)
  );
  always #5 tck_i = ~tck_i;
  task automatic tick();
    @(negedge tck_i);
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic scan(input logic [W-1:0] din, input bit do_upd, output logic [W-1:0] dout);
    cap = 1'b1; tick(); cap = 1'b0;
    for (int i = 0; i < W; i++) begin
      sh = 1'b1; tdi = din[i]; dout[i] = tdo; tick();
    end
    sh = 1'b0;
    if (do_upd) begin upd = 1'b1; tick(); upd = 1'b0; end
  endtask
  task automatic wait_req();
    for (int k = 0; k < 8 && !dmi.req_valid; k++) tick();
    chk("req_valid", dmi.req_valid, 1);
  endtask
  task automatic accept_req();
    dmi.req_ready = 1'b1; tick(); dmi.req_ready = 1'b0;
    chk("resp_ready", dmi.resp_ready, 1);
  endtask
  task automatic respond(input logic [31:0] rd, input logic [1:0] rs);
    dmi.resp_valid = 1'b1; dmi.resp_data = rd; dmi.resp_resp = rs; tick();
    dmi.resp_valid = 1'b0; dmi.resp_resp = 2'd0;
    chk("resp_ready_after", dmi.resp_ready, 0);
  endtask
  task automatic clear_err();
    drst = 1'b1; tick(); drst = 1'b0;
    chk("err_cleared", err, 0);
  endtask
  initial begin
    dmi.req_ready = 1'b0; dmi.resp_valid = 1'b0; dmi.resp_data = '0; dmi.resp_resp = '0;
    vecs[0] = '{7'h10, 32'hDEADBEEF, 2'd2, 32'h0, 2'd0, 7'h10, 32'hDEADBEEF, 2'd0};
    vecs[1] = '{7'h11, 32'h99999999, 2'd1, 32'h12345678, 2'd0, 7'h11, 32'h12345678, 2'd0};
    vecs[2] = '{7'h7F, 32'h00000000, 2'd2, 32'h0, 2'd0, 7'h7F, 32'h00000000, 2'd0};
    vecs[3] = '{7'h00, 32'h0, 2'd1, 32'hFFFFFFFF, 2'd2, 7'h00, 32'hFFFFFFFF, 2'd2};
    vecs[4] = '{7'h22, 32'hAAAA5555, 2'd0, 32'h0, 2'd0, 7'h00, 32'hFFFFFFFF, 2'd0};
    vecs[5] = '{7'h33, 32'h13572468, 2'd3, 32'h0, 2'd0, 7'h00, 32'hFFFFFFFF, 2'd0};
    vecs[6] = '{7'h05, 32'h01234567, 2'd2, 32'h0, 2'd1, 7'h05, 32'h01234567, 2'd2};
    vecs[7] = '{7'h40, 32'h0, 2'd1, 32'hCAFEF00D, 2'd3, 7'h40, 32'hCAFEF00D, 2'd2};
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    chk("rst_tdo", tdo, 0);
    chk("rst_err", err, 0);
    chk("rst_req_valid", dmi.req_valid, 0);
    chk("rst_resp_ready", dmi.resp_ready, 0);
    for (int i = 0; i < 8; i++) begin
      scan({vecs[i].addr, vecs[i].data, vecs[i].op}, 1'b1, d);
      if (vecs[i].op == 2'd1 || vecs[i].op == 2'd2) begin
        wait_req();
        chk("req_addr", dmi.req_addr, vecs[i].addr);
        chk("req_op", dmi.req_op, vecs[i].op);
        if (vecs[i].op == 2'd2) chk("req_data", dmi.req_data, vecs[i].data);
        accept_req();
        respond(vecs[i].rdata, vecs[i].resp);
      end else begin
        tick();
        chk("nop_no_req", dmi.req_valid, 0);
      end
      scan('0, 1'b0, d);
      chk("cap_op", d[1:0], vecs[i].e_op);
      chk("cap_data", d[33:2], vecs[i].e_data);
      chk("cap_addr", d[40:34], vecs[i].e_addr);
      chk("vec_err", err, vecs[i].e_op);
      if (err != 2'd0) clear_err();
    end
    // busy: request held off, capture and update while in flight
    scan({7'h20, 32'h55, 2'd2}, 1'b1, d);
    chk("busy_req_valid", dmi.req_valid, 1);
    scan('0, 1'b0, d);
    chk("busy_cap_op", d[1:0], 3);
    chk("busy_err", err, 3);
    scan({7'h21, 32'h0, 2'd1}, 1'b1, d);
    chk("busy_req_addr_held", dmi.req_addr, 7'h20);
    chk("busy_req_op_held", dmi.req_op, 2);
    cap = 1'b1; drst = 1'b1; tick(); cap = 1'b0; drst = 1'b0;
    chk("clear_beats_busy", err, 0);
    scan('0, 1'b0, d);
    chk("busy_again_err", err, 3);
    accept_req();
    respond(32'h0, 2'd2);
    chk("busy_not_overwritten", err, 3);
    scan({7'h21, 32'h0, 2'd1}, 1'b1, d);
    repeat (3) tick();
    chk("err_blocks_update", dmi.req_valid, 0);
    clear_err();
    scan({7'h21, 32'h0, 2'd1}, 1'b1, d);
    wait_req();
    chk("post_clear_addr", dmi.req_addr, 7'h21);
    accept_req();
    respond(32'h600DF00D, 2'd0);
    scan('0, 1'b0, d);
    chk("post_clear_data", d[33:2], 32'h600DF00D);
    // failed op stays at 2 through a later update and capture
    scan({7'h30, 32'h1111, 2'd2}, 1'b1, d);
    wait_req();
    accept_req();
    respond(32'h0, 2'd2);
    chk("fail_err", err, 2);
    scan({7'h31, 32'h0, 2'd1}, 1'b1, d);
    tick();
    chk("fail_blocks_update", dmi.req_valid, 0);
    scan('0, 1'b0, d);
    chk("fail_cap_op", d[1:0], 2);
    chk("fail_sticky", err, 2);
    clear_err();
    // reset in WaitWrite drops the transaction and its late response
    scan({7'h44, 32'hABCD, 2'd2}, 1'b1, d);
    wait_req();
    accept_req();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("midrst_resp_ready", dmi.resp_ready, 0);
    chk("midrst_req_valid", dmi.req_valid, 0);
    chk("midrst_err", err, 0);
    chk("midrst_tdo", tdo, 0);
    dmi.resp_valid = 1'b1; dmi.resp_data = 32'hBAD; dmi.resp_resp = 2'd2; tick();
    dmi.resp_valid = 1'b0; dmi.resp_resp = 2'd0;
    chk("late_resp_err", err, 0);
    scan('0, 1'b0, d);
    chk("late_resp_dr", d, 0);
    // response timeout
    scan({7'h12, 32'h0, 2'd1}, 1'b1, d);
    wait_req();
    accept_req();
`ifdef DMI_JTAG_DR_TIMEOUT_EN
    begin
      int k;
      k = 0;
      while (dmi.resp_ready && k < 20) begin k++; tick(); end
      chk("timeout_cycles", k, 4);
      chk("timeout_err", err, 2);
    end
`else
    repeat (10) tick();
    chk("wait_indefinite", dmi.resp_ready, 1);
    respond(32'h77, 2'd0);
    chk("wait_done_err", err, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
